// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/control unit:
// stage records, forwarding encodings, branch-stage constants.
package pipe_pkg;

    localparam int REG_AW_MAX = 8;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int BR_EX  = 1;
    localparam int BR_MEM = 2;

    typedef logic [REG_AW_MAX-1:0] reg_t;

    typedef struct packed {
        logic vld;
        reg_t dst;
        logic regwrite;
        logic memread;
        reg_t rs;
        reg_t rt;
        logic use_rs;
        logic use_rt;
    } stage_rec_t;

    // r0 is hardwired zero, so it can never be a hazard source
    function automatic logic rec_match(input stage_rec_t s, input reg_t r);
        return s.vld & s.regwrite & (s.dst == r) & (r != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input stage_rec_t mem,
        input stage_rec_t wb,
        input logic       use_r,
        input reg_t       r
    );
        if (use_r && rec_match(mem, r)) return FWD_EXMEM;
        if (rec_match(wb, r)) return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard query bundle and the control/forwarding answers.
// master = pipeline side driving the ID record, slave = hazard unit.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              id_use_rs_i;
    logic              id_use_rt_i;
    logic [REG_AW-1:0] id_dst_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              branch_taken_i;
    logic              stall_o;
    logic              flush_o;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              id_byp_rs_o;
    logic              id_byp_rt_o;
    logic [2:0]        stage_vld_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i,
        output id_use_rs_i, id_use_rt_i,
        output id_dst_i, id_regwrite_i, id_memread_i,
        output branch_taken_i,
        input  stall_o, flush_o, fwd_a_o, fwd_b_o,
        input  id_byp_rs_o, id_byp_rt_o, stage_vld_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i,
        input  id_use_rs_i, id_use_rt_i,
        input  id_dst_i, id_regwrite_i, id_memread_i,
        input  branch_taken_i,
        output stall_o, flush_o, fwd_a_o, fwd_b_o,
        output id_byp_rs_o, id_byp_rt_o, stage_vld_o,
        output stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter used for stall/flush statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline control: EX/MEM/WB scoreboard, stall, flush, forwarding.
// FORWARD_EN defined: EX forwarding + load-use stall; undefined: stall-only.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 16,
    parameter int BR_STAGE = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pipe_hazard_ctrl_if.slave hz
);
    if (REG_AW > REG_AW_MAX ||
        (BR_STAGE != BR_EX && BR_STAGE != BR_MEM)) begin : g_bad_cfg
        $error("pipe_hazard_ctrl: unsupported REG_AW/BR_STAGE");
    end

    stage_rec_t id_rec;
    stage_rec_t ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;
    logic       ex_hit;
    logic       stall_raw;
    logic       stall;
    logic       flush;

    always_comb begin
        id_rec          = '0;
        id_rec.vld      = hz.id_valid_i;
        id_rec.dst      = reg_t'(hz.id_dst_i);
        id_rec.regwrite = hz.id_regwrite_i;
        id_rec.memread  = hz.id_memread_i;
        id_rec.rs       = reg_t'(hz.id_rs_i);
        id_rec.rt       = reg_t'(hz.id_rt_i);
        id_rec.use_rs   = hz.id_use_rs_i;
        id_rec.use_rt   = hz.id_use_rt_i;
    end

    assign ex_hit = (id_rec.use_rs & rec_match(ex_q, id_rec.rs)) |
                    (id_rec.use_rt & rec_match(ex_q, id_rec.rt));

`ifdef FORWARD_EN
    assign stall_raw  = ex_hit & ex_q.memread;
    assign hz.fwd_a_o = fwd_sel(mem_q, wb_q, ex_q.use_rs, ex_q.rs);
    assign hz.fwd_b_o = fwd_sel(mem_q, wb_q, ex_q.use_rt, ex_q.rt);
`else
    logic mem_hit;

    // Without forwarding the consumer waits until the producer reaches WB
    assign mem_hit = (id_rec.use_rs & rec_match(mem_q, id_rec.rs)) |
                     (id_rec.use_rt & rec_match(mem_q, id_rec.rt));
    assign stall_raw  = ex_hit | mem_hit;
    assign hz.fwd_a_o = FWD_RF;
    assign hz.fwd_b_o = FWD_RF;
`endif

    // A taken branch squashes the consumer, so it never stalls
    assign flush = hz.branch_taken_i;
    assign stall = hz.id_valid_i & stall_raw & ~flush;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= (flush && BR_STAGE == BR_MEM) ? '0 : ex_q;
            ex_q  <= (stall || flush || !hz.id_valid_i) ? '0 : id_rec;
        end
    end

    assign hz.stall_o     = stall;
    assign hz.flush_o     = flush;
    assign hz.id_byp_rs_o = hz.id_use_rs_i & rec_match(wb_q, id_rec.rs);
    assign hz.id_byp_rt_o = hz.id_use_rt_i & rec_match(wb_q, id_rec.rt);
    assign hz.stage_vld_o = {wb_q.vld, mem_q.vld, ex_q.vld};

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall),
        .cnt_o (hz.stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush),
        .cnt_o (hz.flush_cnt_o)
    );

    logic unused_wb;
    assign unused_wb = ^{wb_q.memread, wb_q.rs, wb_q.rt,
                         wb_q.use_rs, wb_q.use_rt};
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle model of the three
// stage records predicts every output; small counters exercise saturation.
module tb_pipe_hazard_ctrl;

    localparam int AW   = 5;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct {
        bit       stall;
        bit       flush;
        bit [1:0] fa;
        bit [1:0] fb;
        bit       brs;
        bit       brt;
        bit [2:0] vld;
        int       sc;
        int       fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(
        .REG_AW   (AW),
        .CNT_W    (CW),
        .BR_STAGE (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   last_stall;

    bit m_vld[3];
    int m_dst[3];
    bit m_rw[3];
    bit m_mr[3];
    int m_rs[3];
    int m_rt[3];
    bit m_urs[3];
    bit m_urt[3];
    int m_sc;
    int m_fc;

    bit s_v, s_urs, s_urt, s_rw, s_mr, s_br;
    int s_rs, s_rt, s_dst;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input int s, input int r);
        return m_vld[s] && m_rw[s] && (m_dst[s] == r) && (r != 0);
    endfunction

    task automatic put(input int i, input bit v, input int dst,
                       input bit rw, input bit mr, input int rs,
                       input int rt, input bit urs, input bit urt);
        m_vld[i] = v;  m_dst[i] = dst; m_rw[i] = rw; m_mr[i] = mr;
        m_rs[i]  = rs; m_rt[i]  = rt;  m_urs[i] = urs; m_urt[i] = urt;
    endtask

    task automatic upd(input bit st, input bit fl);
        if (rst) begin
            for (int i = 0; i < 3; i++) put(i, 0, 0, 0, 0, 0, 0, 0, 0);
            m_sc = 0;
            m_fc = 0;
        end else begin
            if (st && m_sc < MAXC) m_sc++;
            if (fl && m_fc < MAXC) m_fc++;
            put(2, m_vld[1], m_dst[1], m_rw[1], m_mr[1],
                m_rs[1], m_rt[1], m_urs[1], m_urt[1]);
            if (fl) put(1, 0, 0, 0, 0, 0, 0, 0, 0);
            else    put(1, m_vld[0], m_dst[0], m_rw[0], m_mr[0],
                        m_rs[0], m_rt[0], m_urs[0], m_urt[0]);
            if (s_v && !st && !fl)
                put(0, 1, s_dst, s_rw, s_mr, s_rs, s_rt, s_urs, s_urt);
            else
                put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic drive(input bit v, input int rs, input int rt,
                         input bit urs, input bit urt, input int dst,
                         input bit rw, input bit mr, input bit br);
        s_v = v; s_rs = rs; s_rt = rt; s_urs = urs; s_urt = urt;
        s_dst = dst; s_rw = rw; s_mr = mr; s_br = br;
        hz.id_valid_i     = v;
        hz.id_rs_i        = AW'(rs);
        hz.id_rt_i        = AW'(rt);
        hz.id_use_rs_i    = urs;
        hz.id_use_rt_i    = urt;
        hz.id_dst_i       = AW'(dst);
        hz.id_regwrite_i  = rw;
        hz.id_memread_i   = mr;
        hz.branch_taken_i = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc();
        exp_t e;
        exp_t g;
        bit   exh;
        @(negedge clk);
        exh = (s_urs && hit(0, s_rs)) || (s_urt && hit(0, s_rt));
`ifdef FORWARD_EN
        e.stall = s_v && exh && m_mr[0];
        e.fa = (m_urs[0] && hit(1, m_rs[0])) ? 2'd1 :
               hit(2, m_rs[0]) ? 2'd2 : 2'd0;
        e.fb = (m_urt[0] && hit(1, m_rt[0])) ? 2'd1 :
               hit(2, m_rt[0]) ? 2'd2 : 2'd0;
`else
        e.stall = s_v && (exh || (s_urs && hit(1, s_rs)) ||
                                 (s_urt && hit(1, s_rt)));
        e.fa = 2'd0;
        e.fb = 2'd0;
`endif
        if (s_br) e.stall = 1'b0;
        e.flush = s_br;
        e.brs   = s_urs && hit(2, s_rs);
        e.brt   = s_urt && hit(2, s_rt);
        e.vld   = {m_vld[2], m_vld[1], m_vld[0]};
        e.sc    = m_sc;
        e.fc    = m_fc;
        sbq.push_back(e);

        g = sbq.pop_front();
        chk("stall",     32'(hz.stall_o),     32'(g.stall));
        chk("flush",     32'(hz.flush_o),     32'(g.flush));
        chk("fwd_a",     32'(hz.fwd_a_o),     32'(g.fa));
        chk("fwd_b",     32'(hz.fwd_b_o),     32'(g.fb));
        chk("id_byp_rs", 32'(hz.id_byp_rs_o), 32'(g.brs));
        chk("id_byp_rt", 32'(hz.id_byp_rt_o), 32'(g.brt));
        chk("stage_vld", 32'(hz.stage_vld_o), 32'(g.vld));
        chk("stall_cnt", 32'(hz.stall_cnt_o), g.sc);
        chk("flush_cnt", 32'(hz.flush_cnt_o), g.fc);
        last_stall = e.stall;

        @(posedge clk);
        upd(e.stall, e.flush);
        #1;
    endtask

    // ID holds the instruction while it is stalled, as the real pipe does
    task automatic issue(input int rs, input int rt, input bit urs,
                         input bit urt, input int dst, input bit rw,
                         input bit mr);
        drive(1, rs, rt, urs, urt, dst, rw, mr, 0);
        cyc();
        for (int k = 0; k < 4 && last_stall; k++) cyc();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        upd(0, 0);
        #1;
        cyc();
        rst = 1'b0;
        cyc();

        // ALU producer r3, dependent consumers as rs then rt
        issue(1, 2, 1, 1, 3, 1, 0);
        issue(3, 5, 1, 1, 6, 1, 0);
        issue(7, 3, 1, 1, 8, 1, 0);
        repeat (3) cyc();

        // load r4 followed by a consumer of r4 as rt
        issue(1, 0, 1, 0, 4, 1, 1);
        issue(9, 4, 1, 1, 9, 1, 0);
        repeat (3) cyc();

        // fill pipe, then taken branch alongside a load-use hazard
        issue(1, 2, 1, 1, 10, 1, 0);
        issue(1, 2, 1, 1, 11, 1, 0);
        issue(1, 0, 1, 0, 13, 1, 1);
        drive(1, 13, 0, 1, 0, 14, 1, 0, 1);
        cyc();
        idle();
        repeat (3) cyc();

        // r0 never hazards
        issue(1, 2, 1, 1, 0, 1, 1);
        issue(0, 0, 1, 1, 5, 1, 0);
        repeat (3) cyc();

        // reset lands in the middle of a stall
        issue(1, 0, 1, 0, 4, 1, 1);
        drive(1, 4, 4, 1, 1, 6, 1, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle();
        cyc();

        // back-to-back dependent ALU ops
        issue(1, 2, 1, 1, 3, 1, 0);
        issue(3, 0, 1, 0, 7, 1, 0);
        repeat (3) cyc();

        // random traffic over a few registers drives counters to saturation
        for (int n = 0; n < 150; n++) begin
            drive($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4) == 0);
            cyc();
        end
        idle();
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
